// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit
//   Instruction-fetch stage for the RV32I core. Owns the fetch PC and issues at
//   most one outstanding request to instruction memory. Returned words are
//   buffered with their PCs in a DEPTH-entry first-word-fall-through FIFO and
//   handed to decode under backpressure. A redirect (taken branch/jump) flushes
//   the FIFO and drops any response still owed for the old path.
//
// Handshakes (all sampled on the rising edge of clk):
//   request  : a request transfers when imem_req & imem_ready. imem_req may drop
//              without a transfer (it is withdrawn during a redirect cycle).
//   response : imem_rvalid pulses for one cycle, at least one cycle after the
//              request transferred; it carries no ready (always accepted).
//   decode   : the head entry transfers when inst_valid & inst_ready.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   redirect, redirect_pc     taken branch/jump and its target (bits[1:0] ignored)
//   imem_req, imem_addr       request valid and address (= fetch PC)
//   imem_ready                memory accepts the request
//   imem_rvalid, imem_rdata   response valid and instruction word
//   inst_valid, inst_data,
//   inst_pc                   FIFO head toward decode
//   inst_ready                decode consumes the head
//   fsm_state                 debug view of the request FSM (0 FETCH, 1 WAIT, 2 DISCARD)
module riscv_fetch_unit #(
  parameter int               XLEN     = 32,
  parameter int               ILEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic [1:0]      fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] fetch_pc, fetch_pc_next;
  logic [XLEN-1:0] req_pc, req_pc_next;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [ILEN-1:0] data_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic            push;
  logic            pop;
  logic [XLEN-1:0] target;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};

  // Only one request may be owed, and a request is only issued while the FIFO
  // has a free slot, so the eventual push can never overflow.
  assign imem_req  = ~rst & (state == S_FETCH) & (count < CW'(DEPTH)) & ~redirect;
  assign imem_addr = fetch_pc;

  assign inst_valid = (count != '0);
  assign inst_data  = data_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];
  assign pop        = inst_valid & inst_ready;
  assign fsm_state  = state;

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_pc_next   = req_pc;
    push          = 1'b0;
    case (state)
      S_FETCH: begin
        // imem_rvalid here belongs to no request (or predates a reset): ignored.
        if (redirect) begin
          fetch_pc_next = target;
        end else if (imem_req && imem_ready) begin
          req_pc_next   = fetch_pc;
          fetch_pc_next = fetch_pc + XLEN'(4);
          state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_next = target;
          // A response arriving with the redirect is dropped and closes the
          // transaction; otherwise the owed response must still be absorbed.
          state_next    = imem_rvalid ? S_FETCH : S_DISCARD;
        end else if (imem_rvalid) begin
          push       = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (redirect) begin
          fetch_pc_next = target;
        end
        if (imem_rvalid) begin
          state_next = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_pc   <= req_pc_next;
    end
  end

  // A pop in the redirect cycle still completes toward decode; everything left
  // behind it belongs to the wrong path and is flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit. Inputs change on the falling edge; outputs are
// sampled 1 ns later. The reference model tracks the expected fetch address,
// whether a response is owed and whether it will be kept, and the stream of
// {pc, word} decode should receive, held in a queue.
module tb_riscv_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] WPC   = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic [1:0]  fsm_state;

  // wrap-around instance
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_ready = 1'b0;
  logic        w_imem_rvalid = 1'b0;
  logic [31:0] w_imem_rdata = '0;
  logic        w_inst_valid;
  logic [31:0] w_inst_data;
  logic [31:0] w_inst_pc;
  logic        w_inst_ready = 1'b0;
  logic [1:0]  w_fsm_state;

  riscv_fetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) u_dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fsm_state(fsm_state)
  );

  riscv_fetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(WPC)) u_wrap (
    .clk(clk), .rst(rst), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(w_imem_ready),
    .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
    .inst_valid(w_inst_valid), .inst_data(w_inst_data), .inst_pc(w_inst_pc),
    .inst_ready(w_inst_ready), .fsm_state(w_fsm_state)
  );

  int checks = 0;
  int failures = 0;

  // reference model
  logic [63:0] exp_q[$];
  bit          m_out;
  bit          m_discard;
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;

  // memory environment
  bit          mem_owed = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_data = '0;
  int          d_min = 1;
  int          d_max = 1;

  int accepts = 0;
  int pops = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_out     = 1'b0;
    m_discard = 1'b0;
    m_pc      = RPC;
    m_req_pc  = RPC;
  endtask

  // One clock cycle with the given decode/memory/redirect inputs.
  task automatic cycle(input bit rdy, input bit irdy, input bit redir,
                       input logic [31:0] tgt, input bit spur);
    bit          rv;
    bit          exp_req;
    bit          exp_val;
    logic [63:0] head;
    @(negedge clk);
    rv = 1'b0;
    if (mem_owed) begin
      if (mem_wait == 0) rv = 1'b1;
      else mem_wait--;
    end else if (spur) begin
      rv = 1'b1;
    end
    imem_rvalid = rv;
    imem_rdata  = (rv && mem_owed) ? mem_data : 32'($urandom);
    imem_ready  = rdy && !mem_owed;
    inst_ready  = irdy;
    redirect    = redir;
    redirect_pc = tgt;
    #1;
    exp_req = !m_out && (exp_q.size() < DEPTH) && !redir;
    checks++;
    if (imem_req !== exp_req) begin
      failures++;
      $display("FAIL imem_req t=%0t got=%b exp=%b", $time, imem_req, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (imem_addr !== m_pc) begin
        failures++;
        $display("FAIL imem_addr t=%0t got=%h exp=%h", $time, imem_addr, m_pc);
      end
    end
    exp_val = (exp_q.size() != 0);
    checks++;
    if (inst_valid !== exp_val) begin
      failures++;
      $display("FAIL inst_valid t=%0t got=%b exp=%b", $time, inst_valid, exp_val);
    end
    if (exp_val) begin
      head = exp_q[0];
      checks++;
      if ({inst_pc, inst_data} !== head) begin
        failures++;
        $display("FAIL inst_head t=%0t got pc=%h data=%h exp pc=%h data=%h",
                 $time, inst_pc, inst_data, head[63:32], head[31:0]);
      end
      if (irdy) begin
        void'(exp_q.pop_front());
        pops++;
      end
    end
    // model: response, redirect, new acceptance
    if (m_out && rv) begin
      if (!m_discard && !redir) exp_q.push_back({m_req_pc, word_of(m_req_pc)});
      m_out     = 1'b0;
      m_discard = 1'b0;
    end else if (m_out && redir) begin
      m_discard = 1'b1;
    end
    if (redir) begin
      exp_q.delete();
      m_pc = tgt & ~32'h3;
    end
    if (exp_req && imem_ready) begin
      m_out    = 1'b1;
      m_req_pc = m_pc;
      m_pc     = m_pc + 32'd4;
    end
    // memory environment reacts to what the DUT actually did
    if (rv && mem_owed) mem_owed = 1'b0;
    if (imem_req && imem_ready) begin
      accepts++;
      mem_owed = 1'b1;
      mem_wait = $urandom_range(d_max - 1, d_min - 1);
      mem_data = word_of(imem_addr);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst         = 1'b1;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_req got=%b exp=0", imem_req);
    end
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", inst_valid);
    end
    checks++;
    if (imem_addr !== RPC) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=%h", imem_addr, RPC);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_wrap();
    test_reset();
    w_imem_ready = 1'b1;
    #1;
    checks++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== WPC) begin
      failures++;
      $display("FAIL wrap_first got req=%b addr=%h exp req=1 addr=%h", w_imem_req, w_imem_addr, WPC);
    end
    @(negedge clk);
    w_imem_ready  = 1'b0;
    w_imem_rvalid = 1'b1;
    w_imem_rdata  = 32'hCAFE_0001;
    #1;
    checks++;
    if (w_imem_req !== 1'b0) begin
      failures++;
      $display("FAIL wrap_wait_req got=%b exp=0", w_imem_req);
    end
    @(negedge clk);
    w_imem_rvalid = 1'b0;
    w_imem_ready  = 1'b1;
    #1;
    checks++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_second got req=%b addr=%h exp req=1 addr=00000000", w_imem_req, w_imem_addr);
    end
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== WPC || w_inst_data !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL wrap_head got v=%b pc=%h data=%h exp v=1 pc=%h data=cafe0001",
               w_inst_valid, w_inst_pc, w_inst_data, WPC);
    end
    @(negedge clk);
    w_imem_ready = 1'b0;
  endtask

  task automatic test_sequential();
    test_reset();
    d_min = 1; d_max = 1;
    pops = 0;
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (pops != 5) begin
      failures++;
      $display("FAIL seq_rate got pops=%0d exp=5", pops);
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    d_min = 1; d_max = 1;
    accepts = 0;
    repeat (20) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (accepts != DEPTH) begin
      failures++;
      $display("FAIL bp_fill got accepts=%0d exp=%0d", accepts, DEPTH);
    end
    pops = 0;
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (pops < DEPTH) begin
      failures++;
      $display("FAIL bp_drain got pops=%0d exp>=%0d", pops, DEPTH);
    end
  endtask

  task automatic test_redirect_wait();
    test_reset();
    d_min = 3; d_max = 3;
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_2002, 1'b0);
    d_min = 1; d_max = 1;
    pops = 0;
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (pops < 2) begin
      failures++;
      $display("FAIL redir_wait_resume got pops=%0d exp>=2", pops);
    end
  endtask

  task automatic test_redirect_pop();
    int  n;
    int  p0;
    test_reset();
    d_min = 2; d_max = 2;
    n = 0;
    while ((exp_q.size() < 2 || !(mem_owed && mem_wait == 0)) && n < 50) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL redir_pop_setup got cycles=%0d exp<50", n);
    end
    p0 = pops;
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_3000, 1'b0);
    checks++;
    if (pops != p0 + 1) begin
      failures++;
      $display("FAIL redir_pop_delivered got pops=%0d exp=%0d", pops - p0, 1);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    d_min = 1; d_max = 1;
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    test_reset();
    d_min = 3; d_max = 3;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    test_reset();
    d_min = 1; d_max = 1;
    accepts = 0;
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (accepts < 2) begin
      failures++;
      $display("FAIL reset_mid_resume got accepts=%0d exp>=2", accepts);
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    test_reset();
    d_min = 1; d_max = 3;
    for (int i = 0; i < 800; i++) begin
      tgt = 32'h0000_4000 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0, tgt, $urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrap();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
